// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

    localparam int A_W    = 3;
    localparam int B_W    = 3;
    localparam int OP_W   = 2;
    localparam int TAG_W  = 3;
    localparam int CMD_W  = 10;
    localparam int RES_W  = 8;

    // {mode,op} value of the last step of a sweep
    localparam logic [TAG_W-1:0] TAG_LAST = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    // Command FIFO entry layout, MSB first: {sweep, mode, op, a, b}
    typedef struct packed {
        logic            sweep;
        logic            mode;
        logic [OP_W-1:0] op;
        logic [A_W-1:0]  a;
        logic [B_W-1:0]  b;
    } cmd_t;

    // First {mode,op} a command drives: a sweep always starts at octal/op0
    function automatic logic [TAG_W-1:0] first_tag(input cmd_t c);
        return c.sweep ? '0 : {c.mode, c.op};
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Small synchronous FIFO with combinational head read (no fall-through).
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the ALU/decoder datapath from queued commands, waits for the
// datapath to settle, and returns each result with its {mode,op} tag.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [A_W-1:0]   cmd_a,
    input  logic [B_W-1:0]   cmd_b,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic             cmd_mode,
    input  logic             cmd_sweep,
    output logic [A_W-1:0]   alu_a,
    output logic [B_W-1:0]   alu_b,
    output logic [OP_W-1:0]  alu_op,
    output logic             alu_mode,
    input  logic [RES_W-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    cmd_t cmd_in;
    cmd_t cmd_head;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;

    state_t            state_reg,     state_next;
    logic [CNT_W-1:0]  cnt_reg,       cnt_next;
    logic              sweep_reg,     sweep_next;
    logic [A_W-1:0]    alu_a_reg,     alu_a_next;
    logic [B_W-1:0]    alu_b_reg,     alu_b_next;
    logic [TAG_W-1:0]  tag_reg,       tag_next;
    logic              res_valid_reg, res_valid_next;
    logic [RES_W-1:0]  res_data_reg,  res_data_next;
    logic [TAG_W-1:0]  res_tag_reg,   res_tag_next;
    logic              res_last_reg,  res_last_next;

    assign cmd_in    = {cmd_sweep, cmd_mode, cmd_op, cmd_a, cmd_b};
    // Held low during reset so nothing can be queued while flushing
    assign cmd_ready = !fifo_full && !rst;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;

    alu_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .srst  (rst),
        .push  (fifo_push),
        .din   (cmd_in),
        .pop   (fifo_pop),
        .dout  (cmd_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and datapath/result register updates
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        sweep_next     = sweep_reg;
        alu_a_next     = alu_a_reg;
        alu_b_next     = alu_b_reg;
        tag_next       = tag_reg;
        res_valid_next = res_valid_reg;
        res_data_next  = res_data_reg;
        res_tag_next   = res_tag_reg;
        res_last_next  = res_last_reg;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    sweep_next = cmd_head.sweep;
                    alu_a_next = cmd_head.a;
                    alu_b_next = cmd_head.b;
                    tag_next   = first_tag(cmd_head);
                    cnt_next   = CNT_LOAD;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) begin
                    res_data_next  = alu_result;
                    res_tag_next   = tag_reg;
                    res_last_next  = !sweep_reg || (tag_reg == TAG_LAST);
                    res_valid_next = 1'b1;
                    state_next     = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    if (sweep_reg && (tag_reg != TAG_LAST)) begin
                        // op is the low field, so it steps before mode
                        tag_next   = tag_reg + TAG_W'(1);
                        cnt_next   = CNT_LOAD;
                        state_next = SETTLE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight command
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sweep_reg     <= 1'b0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            tag_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_tag_reg   <= '0;
            res_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sweep_reg     <= sweep_next;
            alu_a_reg     <= alu_a_next;
            alu_b_reg     <= alu_b_next;
            tag_reg       <= tag_next;
            res_valid_reg <= res_valid_next;
            res_data_reg  <= res_data_next;
            res_tag_reg   <= res_tag_next;
            res_last_reg  <= res_last_next;
        end
    end

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op    = tag_reg[OP_W-1:0];
    assign alu_mode  = tag_reg[TAG_W-1];
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_tag   = res_tag_reg;
    assign res_last  = res_last_reg;
    assign busy      = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU/decoder stub.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_a;
    logic [2:0] cmd_b;
    logic [1:0] cmd_op;
    logic       cmd_mode;
    logic       cmd_sweep;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [1:0] alu_op;
    logic       alu_mode;
    logic [7:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_tag;
    logic       res_last;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_op_sequencer #(
        .FIFO_DEPTH    (4),
        .SETTLE_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .cmd_mode   (cmd_mode),
        .cmd_sweep  (cmd_sweep),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_mode   (alu_mode),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .res_last   (res_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stub: op 0..3 = add/sub/and/xor (3-bit); mode 0 = one-hot
    // octal decode, mode 1 = Gray code tagged with 5'b10100 in the MSBs
    function automatic logic [7:0] dp_model(input logic [2:0] a, input logic [2:0] b,
                                            input logic [1:0] op, input logic mode);
        logic [2:0] r;
        case (op)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a & b;
            default: r = a ^ b;
        endcase
        if (!mode) return 8'd1 << r;
        return {5'b10100, r ^ (r >> 1)};
    endfunction

    always_comb alu_result = dp_model(alu_a, alu_b, alu_op, alu_mode);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [7:0] d, input logic [2:0] t,
                             input logic l);
        $display("result %s: data=%02h tag=%0d last=%0b", tag, res_data, res_tag, res_last);
        check({tag, " valid"}, res_valid, 1'b1);
        check({tag, " data"}, res_data, d);
        check({tag, " tag"}, res_tag, t);
        check({tag, " last"}, res_last, l);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " res_valid"}, res_valid, 1'b0);
        check({tag, " res_data"}, res_data, 8'h00);
        check({tag, " res_tag"}, res_tag, 3'd0);
        check({tag, " res_last"}, res_last, 1'b0);
        check({tag, " alu"}, {alu_a, alu_b, alu_op, alu_mode}, 9'd0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " cmd_ready"}, cmd_ready, 1'b0);
    endtask

    // Offer one command for one cycle, starting at a falling edge
    task automatic push_cmd(input logic sw, input logic md, input logic [1:0] op,
                            input logic [2:0] a, input logic [2:0] b);
        cmd_valid = 1'b1;
        cmd_sweep = sw;
        cmd_mode  = md;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        $display("push sweep=%0b mode=%0b op=%0d a=%0d b=%0d", sw, md, op, a, b);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Advance at least one cycle, then until res_valid (bounded)
    task automatic wait_res(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 20);
    endtask

    // Sweep of a=5,b=3: octal 01,04,02,40 then Gray A0,A3,A1,A5
    logic [7:0] sw_data [8] = '{8'h01, 8'h04, 8'h02, 8'h40, 8'hA0, 8'hA3, 8'hA1, 8'hA5};

    // Backpressure set: {mode,op,a,b} and expected data
    logic [8:0] bp_cmd  [5] = '{{1'b0, 2'd0, 3'd1, 3'd2}, {1'b1, 2'd1, 3'd6, 3'd3},
                                {1'b0, 2'd2, 3'd6, 3'd5}, {1'b1, 2'd3, 3'd3, 3'd5},
                                {1'b0, 2'd0, 3'd7, 3'd2}};
    logic [7:0] bp_data [5] = '{8'h08, 8'hA2, 8'h10, 8'hA5, 8'h02};

    // Streaming set across the pointer wrap
    logic [8:0] st_cmd  [10] = '{{1'b0, 2'd0, 3'd0, 3'd1}, {1'b0, 2'd0, 3'd1, 3'd1},
                                 {1'b1, 2'd0, 3'd2, 3'd1}, {1'b1, 2'd0, 3'd3, 3'd1},
                                 {1'b0, 2'd1, 3'd4, 3'd1}, {1'b1, 2'd1, 3'd5, 3'd1},
                                 {1'b0, 2'd2, 3'd6, 3'd3}, {1'b1, 2'd2, 3'd7, 3'd5},
                                 {1'b0, 2'd3, 3'd2, 3'd5}, {1'b1, 2'd3, 3'd4, 3'd4}};
    logic [7:0] st_data [10] = '{8'h02, 8'h04, 8'hA2, 8'hA6, 8'h08,
                                 8'hA6, 8'h04, 8'hA7, 8'h80, 8'hA0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pi;
        int ri;
        int cyc;
        logic [8:0] c;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        cmd_mode  = 1'b0;
        cmd_sweep = 1'b0;
        res_ready = 1'b1;

        // Power-up reset
        repeat (2) @(negedge clk);
        check_reset_outputs("init rst");
        rst = 1'b0;
        @(negedge clk);
        check("init cmd_ready after rst", cmd_ready, 1'b1);
        check("init busy after rst", busy, 1'b0);

        // Single command 7,7,op2,octal
        push_cmd(1'b0, 1'b0, 2'd2, 3'd7, 3'd7);
        check("single alu before pop", {alu_a, alu_b}, 6'd0);
        wait_res(n);
        check("single latency", n, 2);
        check_res("single", 8'h80, 3'd2, 1'b1);
        check("single alu", {alu_a, alu_b, alu_op, alu_mode}, {3'd7, 3'd7, 2'd2, 1'b0});
        check("single busy", busy, 1'b1);
        @(negedge clk);
        check("single valid drop", res_valid, 1'b0);
        check("single idle busy", busy, 1'b0);

        // Sweep 5,3; op/mode fields must be ignored
        push_cmd(1'b1, 1'b1, 2'd3, 3'd5, 3'd3);
        for (int i = 0; i < 8; i++) begin
            wait_res(n);
            check($sformatf("sweep latency %0d", i), n, 2);
            check_res($sformatf("sweep %0d", i), sw_data[i], 3'(i), i == 7);
            check($sformatf("sweep alu %0d", i), {alu_a, alu_b, alu_mode, alu_op},
                  {3'd5, 3'd3, 3'(i)});
        end
        @(negedge clk);
        check("sweep end valid", res_valid, 1'b0);
        check("sweep end busy", busy, 1'b0);

        // Backpressure: five commands with the consumer stalled
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c = bp_cmd[i];
            cmd_valid = 1'b1;
            cmd_sweep = 1'b0;
            {cmd_mode, cmd_op, cmd_a, cmd_b} = c;
            check($sformatf("bp ready %0d", i), cmd_ready, 1'b1);
            $display("push mode=%0b op=%0d a=%0d b=%0d", c[8], c[7:6], c[5:3], c[2:0]);
            @(negedge clk);
        end
        // Offer an extra command while full; it must never be accepted
        cmd_mode = 1'b1;
        cmd_op   = 2'd2;
        cmd_a    = 3'd7;
        cmd_b    = 3'd7;
        check("bp full", cmd_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp hold %0d", k), {res_valid, res_data, res_tag},
                  {1'b1, bp_data[0], 3'd0});
            check($sformatf("bp still full %0d", k), cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                wait_res(n);
                check($sformatf("bp b2b latency %0d", i), n, 3);
            end
            c = bp_cmd[i];
            check_res($sformatf("bp %0d", i), bp_data[i], c[8:6], 1'b1);
        end
        @(negedge clk);
        check("bp end valid", res_valid, 1'b0);
        check("bp end busy", busy, 1'b0);

        // Streaming with simultaneous push/pop across the pointer wrap
        pi  = 0;
        ri  = 0;
        cyc = 0;
        while (ri < 10 && cyc < 200) begin
            if (res_valid) begin
                c = st_cmd[ri];
                check_res($sformatf("stream %0d", ri), st_data[ri], c[8:6], 1'b1);
                ri++;
            end
            if (pi < 10) begin
                c = st_cmd[pi];
                cmd_valid = 1'b1;
                cmd_sweep = 1'b0;
                {cmd_mode, cmd_op, cmd_a, cmd_b} = c;
                if (cmd_ready) pi++;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        check("stream result count", ri, 10);
        check("stream push count", pi, 10);
        check("stream end valid", res_valid, 1'b0);
        check("stream end busy", busy, 1'b0);

        // Reset in the middle of a sweep, after the third result
        push_cmd(1'b1, 1'b0, 2'd0, 3'd5, 3'd3);
        for (int i = 0; i < 3; i++) begin
            wait_res(n);
            check_res($sformatf("mid sweep %0d", i), sw_data[i], 3'(i), 1'b0);
        end
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_sweep = 1'b0;
        cmd_mode  = 1'b0;
        cmd_op    = 2'd0;
        cmd_a     = 3'd1;
        cmd_b     = 3'd1;
        @(negedge clk);
        check_reset_outputs("mid rst cycle1");
        @(negedge clk);
        check_reset_outputs("mid rst cycle2");
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("post rst cmd_ready", cmd_ready, 1'b1);
        check("post rst busy", busy, 1'b0);
        check("post rst valid", res_valid, 1'b0);

        // New command after reset: 3,5,op3,Gray -> xor 6 -> Gray 5
        push_cmd(1'b0, 1'b1, 2'd3, 3'd3, 3'd5);
        wait_res(n);
        check("post rst latency", n, 2);
        check_res("post rst", 8'hA5, 3'd7, 1'b1);
        @(negedge clk);
        check("post rst end valid", res_valid, 1'b0);
        check("post rst end busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command sequencer that owns the inputs of the ALU/decoder datapath (3-bit A and B operands, 2-bit op select, octal/Gray decoder mode bit). Requesters enqueue operations through a valid/ready port into a small FIFO. The block drives the datapath from registers, waits a programmable settle time, captures the result, and returns it with a tag through a valid/ready result port. A sweep command runs all 4 ops × 2 modes on one operand pair automatically, replacing hand-stepped stimulus.

## Interface
Parameters:
- FIFO_DEPTH, 4, command FIFO entries; must be a power of 2 and ≥2.
- SETTLE_CYCLES, 1, cycles the datapath inputs are held before capture; must be ≥1.

Ports:
- clk  in  1  system clock; one clock; reset `rst` is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_a  in  3  operand A.
- cmd_b  in  3  operand B.
- cmd_op  in  2  op select (ignored when cmd_sweep=1).
- cmd_mode  in  1  0=octal decoder, 1=Gray decoder (ignored when cmd_sweep=1).
- cmd_sweep  in  1  1 = run all 8 {mode,op} combinations.
- alu_a  out  3  registered operand A to datapath.
- alu_b  out  3  registered operand B to datapath.
- alu_op  out  2  registered op select.
- alu_mode  out  1  registered decoder mode.
- alu_result  in  8  combinational datapath output.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  captured alu_result.
- res_tag  out  3  {mode,op} that produced res_data.
- res_last  out  1  last result of the current command.
- busy  out  1  state!=IDLE or FIFO non-empty.

## Operation
- FIFO entry: {sweep,mode,op,a,b}, 10 bits. Push on cmd_valid && cmd_ready. No fall-through.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE: if the FIFO is non-empty, pop the entry into the working register.
  - Load idx = 3'b000 if sweep=1, else {mode,op}.
  - Drive alu_* from the popped entry and idx. Load settle counter with SETTLE_CYCLES. Go to SETTLE.
- SETTLE: decrement the counter. On the final count, capture alu_result into res_data and idx into res_tag.
  - res_last = !sweep || idx==3'b111. Set res_valid. Go to HOLD.
- HOLD: hold res_valid, res_data, res_tag and res_last stable until res_ready.
  - On handshake, if sweep && idx!=3'b111: idx+1 (op is the low bits and steps first, then mode). Update alu_op/alu_mode, reload the counter, go to SETTLE, and clear res_valid.
  - Otherwise clear res_valid and go to IDLE.
- alu_* hold their last values in IDLE.
- Boundaries:
  - Push while full: impossible (cmd_ready=0).
  - Push and pop in the same cycle: both occur; count is unchanged.
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - cmd_* are don't-care when cmd_valid=0.
- Reset (at any time, including mid-sweep): FIFO flushed, FSM to IDLE, the in-flight command discarded.
  - Outputs are 0 from the edge at which rst is sampled, except cmd_ready, which is 0 while rst=1 and 1 on the first cycle after.

## Timing
- All outputs are registered except cmd_ready (from full) and busy (from state and count), which are decoded from registers.
- Single command, empty FIFO, accepted in cycle N:
  - Pop and alu_* update at the end of N+1.
  - SETTLE occupies N+2 through N+1+SETTLE_CYCLES.
  - res_valid is high from cycle N+2+SETTLE_CYCLES (N+3 at the default).
- Sweep step: after a result handshake in cycle M, res_valid is low in M+1..M+SETTLE_CYCLES and high in M+1+SETTLE_CYCLES.
- Back-to-back commands: after the final handshake in cycle M, IDLE in M+1, next result at M+2+SETTLE_CYCLES.
- Throughput is at most one result per 1+SETTLE_CYCLES cycles within a sweep.

## Structure
- Package alu_seq_pkg: state enum (IDLE, SETTLE, HOLD); command field widths (A_W=3, B_W=3, OP_W=2, CMD_W=10); result width RES_W=8; tag constant TAG_LAST=3'b111.
- Sub-module alu_seq_fifo: synchronous FIFO, parameterised depth and width, with push, pop, full and empty.
- FSM, counter, idx and the output registers live in the top module.

## Test plan
- Reset: hold rst for 2 cycles mid-traffic -> every output is 0; cmd_ready=0 while rst=1 and 1 in the next cycle; busy=0.
- Single command a=7, b=7, op=2, mode=0, res_ready=1 -> res_valid exactly 3 cycles after accept (SETTLE_CYCLES=1).
  - Also: res_tag=3'b010, res_last=1, res_data equals the datapath model for (7,7,op2,octal), alu_*={7,7,2,0}.
- Sweep a=5, b=3 -> 8 results with tags 000,001,…,111 in order; res_last=1 only on the 8th; each res_data matches the model.
- Backpressure: hold res_ready=0 and push 5 commands -> res_data/res_tag stay stable, cmd_ready drops after 4 queued entries.
  - Then release res_ready -> all results return in FIFO order.
- Wrap and simultaneous push/pop: stream 10 single commands with res_ready=1 so pushes coincide with pops -> no loss or duplication, correct order across the pointer wrap.
- Reset mid-sweep after the 3rd result -> res_valid=0 on the next cycle, FIFO empty, busy=0.
  - A new command afterwards completes normally with 3-cycle latency.
